mips_iter_divider: RTL and testbench
====================================

Name: mips_iter_divider

Overview:
Multi-cycle radix-2 restoring divider for the pipelined MIPS core. It executes DIV and DIVU and writes the HI/LO register pair. It is the shift-subtract counterpart to the single-cycle combinational shift unit, and is driven from EX with a start/busy/done handshake; the hazard unit stalls MFHI/MFLO while busy=1. Signed operation is magnitude division with sign correction; the remainder takes the sign of the dividend (MIPS semantics).

Parameters:
WIDTH, 32, operand, quotient and remainder width; latency scales as WIDTH+1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active high
start  input  1  request a division; sampled only when busy=0
is_signed  input  1  1=DIV (two's complement), 0=DIVU
dividend  input  WIDTH  rs operand, sampled with start
divisor  input  WIDTH  rt operand, sampled with start
flush  input  1  pipeline exception/flush; abort any in-flight operation
busy  output  1  operation in progress; new start ignored
done  output  1  one-cycle pulse; hi/lo hold new result in this cycle
div_zero  output  1  pulses with done when divisor was 0
hi  output  WIDTH  remainder register (HI)
lo  output  WIDTH  quotient register (LO)

Behaviour:
- One clock domain. rst is synchronous and active high. All outputs are registered.
- Reset values: busy=0, done=0, div_zero=0, hi=0, lo=0; state=IDLE; iteration counter=0.
- States:
  - IDLE: start=1 with divisor!=0 latches |dividend| and |divisor| (magnitudes when is_signed=1, raw values otherwise), plus quotient sign (sign(a) XOR sign(b)) and remainder sign (sign(a)). Go to CALC with count=0.
  - IDLE, divisor==0: go straight to FINISH with lo=all ones, hi=dividend and div_zero=1, regardless of is_signed.
  - CALC: each cycle shift {rem,quo} left by 1, trial-subtract divisor from rem, and restore if negative; set the quotient bit to 1 when no borrow. After count==WIDTH-1, go to FINISH.
  - FINISH: hi/lo are written on entry, with the quotient negated if quotient sign=1 and the remainder negated if remainder sign=1 (signed only). done=1 for exactly this cycle. Returns to IDLE, or accepts a new start (back-to-back).
- Timing: start accepted in cycle N, divisor!=0:
  - busy=1 in cycles N+1..N+WIDTH; CALC lasts WIDTH cycles.
  - done=1, busy=0 and hi/lo valid in cycle N+WIDTH+1 (N+33 at default).
  - Divisor==0: done in cycle N+1.
- start is accepted only when busy=0, i.e. in IDLE or FINISH. A start while busy=1 is ignored and its operands are discarded.
- hi/lo change only on entry to FINISH. They hold across IDLE, across flush, and during the next operation until it finishes.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no flag.
- Magnitude of 0x80000000 is the unsigned value 0x80000000; the internal datapath is WIDTH+1 bits for the trial subtract.
- flush=1 in any cycle: next state is IDLE, busy=0, done=0, and hi/lo are unchanged. If start and flush occur in the same cycle, flush wins and start is dropped.
- rst mid-operation: all state and outputs return to reset values on the next edge; rst overrides flush and start.
- div_zero is 0 whenever done is 0.

Test Plan:
1. DIVU 100/7, start at cycle 0 -> busy=1 cycles 1..32; done=1 at cycle 33; lo=14, hi=2, div_zero=0.
2. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
3. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
4. DIVU 1234/0 -> done and div_zero at cycle 1; lo=0xFFFFFFFF, hi=1234. Back-to-back start in the FINISH cycle is accepted and its done lands 33 cycles later.
5. DIVU 100/7 then flush at cycle 10 -> no done pulse, busy=0 at cycle 11, hi/lo keep prior result. Start asserted at cycle 5 of an operation -> ignored; the original result is unchanged.
6. rst at cycle 20 of an operation -> cycle 21: busy=0, done=0, hi=0, lo=0. A new DIVU 9/3 then yields lo=3, hi=0.

Source files
------------

// File: rtl/mips_iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU: magnitude division with sign correction,
// writing HI (remainder) and LO (quotient) through a start/busy/done handshake.
module mips_iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic [WIDTH-1:0] rem_r, rem_s;
    logic [WIDTH-1:0] quo_r, quo_s;
    logic [WIDTH-1:0] dvs_r, dvs_s;
    logic             q_neg_r, q_neg_s;
    logic             r_neg_r, r_neg_s;
    logic             busy_r, done_r, div_zero_r;
    logic             div_zero_s;
    logic [WIDTH-1:0] hi_r, hi_s;
    logic [WIDTH-1:0] lo_r, lo_s;

    logic [WIDTH-1:0] abs_a_s, abs_b_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] diff_s;
    logic             borrow_s;
    logic [WIDTH-1:0] step_rem_s, step_quo_s;

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

    // One shift-subtract step; the remainder stays below the divisor, so WIDTH bits hold it.
    always_comb begin
        abs_a_s    = (is_signed && dividend[WIDTH-1]) ? negate(dividend) : dividend;
        abs_b_s    = (is_signed && divisor[WIDTH-1])  ? negate(divisor)  : divisor;
        shifted_s  = {rem_r, quo_r[WIDTH-1]};
        diff_s     = {1'b0, shifted_s} - {2'b00, dvs_r};
        borrow_s   = diff_s[WIDTH+1];
        step_rem_s = borrow_s ? shifted_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
        step_quo_s = {quo_r[WIDTH-2:0], ~borrow_s};
    end

    // Next-state and next-output logic; flush aborts and leaves HI/LO untouched.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        rem_s      = rem_r;
        quo_s      = quo_r;
        dvs_s      = dvs_r;
        q_neg_s    = q_neg_r;
        r_neg_s    = r_neg_r;
        hi_s       = hi_r;
        lo_s       = lo_r;
        div_zero_s = 1'b0;
        if (flush) begin
            state_s = IDLE;
            count_s = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE, FINISH: begin
                    if (start) begin
                        if (divisor == {WIDTH{1'b0}}) begin
                            state_s    = FINISH;
                            lo_s       = {WIDTH{1'b1}};
                            hi_s       = dividend;
                            div_zero_s = 1'b1;
                        end else begin
                            state_s = CALC;
                            count_s = {CNT_W{1'b0}};
                            rem_s   = {WIDTH{1'b0}};
                            quo_s   = abs_a_s;
                            dvs_s   = abs_b_s;
                            q_neg_s = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_neg_s = is_signed & dividend[WIDTH-1];
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                CALC: begin
                    rem_s = step_rem_s;
                    quo_s = step_quo_s;
                    if (count_r == LAST_CNT) begin
                        state_s = FINISH;
                        lo_s    = q_neg_r ? negate(step_quo_s) : step_quo_s;
                        hi_s    = r_neg_r ? negate(step_rem_s) : step_rem_s;
                    end else begin
                        count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_s = IDLE;
                    count_s = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State and registered outputs; synchronous reset has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            count_r    <= {CNT_W{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            dvs_r      <= {WIDTH{1'b0}};
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            rem_r      <= rem_s;
            quo_r      <= quo_s;
            dvs_r      <= dvs_s;
            q_neg_r    <= q_neg_s;
            r_neg_r    <= r_neg_s;
            busy_r     <= (state_s == CALC);
            done_r     <= (state_s == FINISH);
            div_zero_r <= div_zero_s;
            hi_r       <= hi_s;
            lo_r       <= lo_s;
        end
    end

endmodule

// File: tb/tb_mips_iter_divider.sv
// Directed bench for mips_iter_divider: latency, signed/unsigned results, divide by
// zero, back-to-back, flush, ignored start and mid-operation reset.
module tb_mips_iter_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    mips_iter_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one start in a cycle; returns #1 after the accepting edge (cycle 1).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b; is_signed = sgn;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int lat);
        lat = c0;
        while (done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vectors++;
        if ({busy, done, div_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h, need all 0", busy, done, div_zero, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_divu_timing();
        int bad = 0;
        issue(32'd100, 32'd7, 1'b0);
        for (int c = 1; c <= 32; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL divu_busy: %0d of cycles 1..32 lacked busy=1 done=0, need 0", bad);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || div_zero !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
            miscompares++;
            $display("FAIL divu_c33: done=%b busy=%b dz=%b lo=%0d hi=%0d, need 1 0 0 14 2", done, busy, div_zero, lo, hi);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
            miscompares++;
            $display("FAIL divu_hold: done=%b lo=%0d hi=%0d, need 0 14 2", done, lo, hi);
        end
    endtask

    task automatic test_signed();
        logic [31:0] ta [6] = '{32'hFFFFFFF9, 32'd7,        32'h80000000, 32'hFFFFFFFF, 32'hFFFFFF9C, 32'h80000000};
        logic [31:0] tb [6] = '{32'd2,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFF9, 32'd2};
        logic        ts [6] = '{1'b1,         1'b1,         1'b1,         1'b0,         1'b1,         1'b1};
        logic [31:0] tq [6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd14,       32'hC0000000};
        logic [31:0] tr [6] = '{32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'hFFFFFFFE, 32'd0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            tick();
            issue(ta[i], tb[i], ts[i]);
            wait_done(1, lat);
            vectors++;
            if (lat != 33 || lo !== tq[i] || hi !== tr[i] || div_zero !== 1'b0) begin
                miscompares++;
                $display("FAIL signed_%0d: lat=%0d lo=%h hi=%h dz=%b, need 33 %h %h 0", i, lat, lo, hi, div_zero, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_div_zero_back_to_back();
        int lat;
        tick();
        issue(32'd1234, 32'd0, 1'b0);
        vectors++;
        if (done !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b0 || lo !== 32'hFFFFFFFF || hi !== 32'd1234) begin
            miscompares++;
            $display("FAIL divzero_u: done=%b dz=%b busy=%b lo=%h hi=%0d, need 1 1 0 ffffffff 1234", done, div_zero, busy, lo, hi);
        end
        issue(32'hFFFFFFF9, 32'd0, 1'b1);
        vectors++;
        if (done !== 1'b1 || div_zero !== 1'b1 || lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin
            miscompares++;
            $display("FAIL divzero_s: done=%b dz=%b lo=%h hi=%h, need 1 1 ffffffff fffffff9", done, div_zero, lo, hi);
        end
        issue(32'd100, 32'd7, 1'b0);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || div_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b done=%b dz=%b, need 1 0 0", busy, done, div_zero);
        end
        wait_done(1, lat);
        vectors++;
        if (lat != 33 || lo !== 32'd14 || hi !== 32'd2 || div_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_result: lat=%0d lo=%0d hi=%0d dz=%b, need 33 14 2 0", lat, lo, hi, div_zero);
        end
    endtask

    task automatic test_flush();
        int lat;
        int seen = 0;
        tick();
        issue(32'd50, 32'd8, 1'b0);
        wait_done(1, lat);
        vectors++;
        if (lat != 33 || lo !== 32'd6 || hi !== 32'd2) begin
            miscompares++;
            $display("FAIL flush_prior: lat=%0d lo=%0d hi=%0d, need 33 6 2", lat, lo, hi);
        end
        tick();
        issue(32'd100, 32'd7, 1'b0);
        repeat (9) tick();
        @(negedge clk);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || lo !== 32'd6 || hi !== 32'd2) begin
            miscompares++;
            $display("FAIL flush_c11: busy=%b done=%b lo=%0d hi=%0d, need 0 0 6 2", busy, done, lo, hi);
        end
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        vectors++;
        if (seen != 0 || lo !== 32'd6 || hi !== 32'd2) begin
            miscompares++;
            $display("FAIL flush_quiet: %0d busy/done cycles, lo=%0d hi=%0d, need 0 6 2", seen, lo, hi);
        end
        @(negedge clk);
        start = 1'b1; flush = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
        tick();
        start = 1'b0; flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_start: busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_ignored_start();
        int lat;
        int seen = 0;
        tick();
        issue(32'd100, 32'd7, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0;
        tick();
        start = 1'b0;
        wait_done(6, lat);
        vectors++;
        if (lat != 33 || lo !== 32'd14 || hi !== 32'd2) begin
            miscompares++;
            $display("FAIL ignored_start: lat=%0d lo=%0d hi=%0d, need 33 14 2", lat, lo, hi);
        end
        tick();
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        vectors++;
        if (seen != 0 || lo !== 32'd14) begin
            miscompares++;
            $display("FAIL ignored_spawn: %0d busy/done cycles lo=%0d, need 0 14", seen, lo);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(32'd100, 32'd7, 1'b0);
        repeat (19) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({busy, done, div_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b done=%b dz=%b hi=%h lo=%h, need all 0", busy, done, div_zero, hi, lo);
        end
        issue(32'd9, 32'd3, 1'b0);
        wait_done(1, lat);
        vectors++;
        if (lat != 33 || lo !== 32'd3 || hi !== 32'd0) begin
            miscompares++;
            $display("FAIL after_reset: lat=%0d lo=%0d hi=%0d, need 33 3 0", lat, lo, hi);
        end
    endtask

    initial begin
        test_reset();
        test_divu_timing();
        test_signed();
        test_div_zero_back_to_back();
        test_flush();
        test_ignored_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
